// File: rtl/mlp_mon_pkg.sv
// Shared types and constants for the MLP run monitor: FSM states, mailbox
// register offsets and the default completion code.
package mlp_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } mon_state_e;

  localparam logic [31:0] MBOX_IDX_OFS  = 32'h0;
  localparam logic [31:0] MBOX_RES_OFS  = 32'h4;
  localparam logic [31:0] MBOX_EXIT_OFS = 32'h8;

  localparam int DEF_EXIT_CODE = 99999;

endpackage

// File: rtl/mlp_mon_decode.sv
// Per-channel mailbox decoder: turns one snooped dmem write into register hits.
module mlp_mon_decode
  import mlp_mon_pkg::*;
#(
  parameter int                DWidth = 32,
  parameter logic [DWidth-1:0] Base   = '0
)(
  input  logic              req,
  input  logic              write,
  input  logic              ready,
  input  logic [DWidth-1:0] addr,
  input  logic [DWidth-1:0] bus_wdata,
  output logic              hit_idx,
  output logic              hit_res,
  output logic              hit_exit,
  output logic              res_bit,
  output logic [DWidth-1:0] wdata
);

  logic accepted;

  // Only completed, word-aligned writes can ever reach a mailbox register.
  assign accepted = req && write && ready && (addr[1:0] == 2'b00);

  assign hit_idx  = accepted && (addr == Base + DWidth'(MBOX_IDX_OFS));
  assign hit_res  = accepted && (addr == Base + DWidth'(MBOX_RES_OFS));
  assign hit_exit = accepted && (addr == Base + DWidth'(MBOX_EXIT_OFS));
  assign res_bit  = bus_wdata[0];
  assign wdata    = bus_wdata;

endmodule

// File: rtl/mlp_run_monitor.sv
// Snoops NumCh dmem ports for mailbox writes and accumulates run statistics.
// Optional per-channel RESULT latency tracking: define MLP_RUN_MONITOR_LAT_EN.
module mlp_run_monitor
  import mlp_mon_pkg::*;
#(
  parameter int                DWidth     = 32,
  parameter int                NumCh      = 2,
  parameter logic [DWidth-1:0] MboxBase   = DWidth'(32'h0200_3F00),
  parameter logic [DWidth-1:0] MboxStride = DWidth'(32'h10),
  parameter int                NumOfTest  = 1000,
  parameter int                ExitCode   = DEF_EXIT_CODE,
  parameter logic [31:0]       TimeoutCyc = 32'h0FFF_FFFF,
  parameter int                CntWidth   = 16
)(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [NumCh-1:0]        dmem_req_i,
  input  logic [NumCh-1:0]        dmem_write_i,
  input  logic [NumCh-1:0]        dmem_ready_i,
  input  logic [NumCh*DWidth-1:0] dmem_addr_i,
  input  logic [NumCh*DWidth-1:0] dmem_wdata_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    timeout_o,
  output logic [CntWidth-1:0]     test_cnt_o,
  output logic [CntWidth-1:0]     correct_cnt_o,
  output logic [63:0]             cycle_cnt_o,
  output logic [NumCh-1:0]        ch_exit_o,
`ifdef MLP_RUN_MONITOR_LAT_EN
  output logic [NumCh*32-1:0]     lat_min_o,
  output logic [NumCh*32-1:0]     lat_max_o,
`endif
  output logic [NumCh*DWidth-1:0] last_idx_o
);

  localparam logic [DWidth-1:0] ExitVal    = DWidth'(ExitCode);
  localparam logic [31:0]       NumOfTestV = 32'(NumOfTest);

  mon_state_e              state_q;
  logic [CntWidth-1:0]     test_q, corr_q, test_nxt, corr_nxt;
  logic [CntWidth:0]       res_k, res_pc, test_sum, corr_sum;
  logic [63:0]             cyc_q, cyc_nxt;
  logic [31:0]             wdog_q, wdog_nxt;
  logic [NumCh-1:0]        exit_q, exit_nxt;
  logic [NumCh*DWidth-1:0] idx_q, idx_nxt;
  logic                    any_hit, done_hit;

  logic [NumCh-1:0]        hit_idx, hit_res, hit_exit, res_bit;
  logic [NumCh*DWidth-1:0] ch_wdata;

  for (genvar c = 0; c < NumCh; c++) begin : g_dec
    localparam logic [DWidth-1:0] ChBase = MboxBase + MboxStride * DWidth'(c);
    mlp_mon_decode #(
      .DWidth (DWidth),
      .Base   (ChBase)
    ) u_dec (
      .req       (dmem_req_i[c]),
      .write     (dmem_write_i[c]),
      .ready     (dmem_ready_i[c]),
      .addr      (dmem_addr_i[c*DWidth +: DWidth]),
      .bus_wdata (dmem_wdata_i[c*DWidth +: DWidth]),
      .hit_idx   (hit_idx[c]),
      .hit_res   (hit_res[c]),
      .hit_exit  (hit_exit[c]),
      .res_bit   (res_bit[c]),
      .wdata     (ch_wdata[c*DWidth +: DWidth])
    );
  end

  // Merge all channels' hits into one next-state view so that simultaneous
  // RESULT writes land in a single update and completion sees this cycle.
  always_comb begin
    res_k    = '0;
    res_pc   = '0;
    any_hit  = 1'b0;
    exit_nxt = exit_q;
    idx_nxt  = idx_q;
    for (int c = 0; c < NumCh; c++) begin
      if (hit_idx[c] || hit_res[c] || hit_exit[c]) any_hit = 1'b1;
      if (hit_idx[c]) idx_nxt[c*DWidth +: DWidth] = ch_wdata[c*DWidth +: DWidth];
      if (hit_res[c]) begin
        res_k  = res_k + {{CntWidth{1'b0}}, 1'b1};
        res_pc = res_pc + {{CntWidth{1'b0}}, res_bit[c]};
      end
      if (hit_exit[c] && (ch_wdata[c*DWidth +: DWidth] == ExitVal)) exit_nxt[c] = 1'b1;
    end
    test_sum = {1'b0, test_q} + res_k;
    corr_sum = {1'b0, corr_q} + res_pc;
    test_nxt = test_sum[CntWidth] ? '1 : test_sum[CntWidth-1:0];
    corr_nxt = corr_sum[CntWidth] ? '1 : corr_sum[CntWidth-1:0];
    cyc_nxt  = (&cyc_q) ? cyc_q : cyc_q + 64'd1;
    wdog_nxt = any_hit ? 32'd0 : wdog_q + 32'd1;
    done_hit = (&exit_nxt) || (32'(test_nxt) >= NumOfTestV);
  end

  // start_i wins in every state; it also drops any write of the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      test_q  <= '0;
      corr_q  <= '0;
      cyc_q   <= '0;
      wdog_q  <= '0;
      exit_q  <= '0;
      idx_q   <= '0;
    end else if (start_i) begin
      state_q <= ST_RUN;
      test_q  <= '0;
      corr_q  <= '0;
      cyc_q   <= '0;
      wdog_q  <= '0;
      exit_q  <= '0;
      idx_q   <= '0;
    end else if (state_q == ST_RUN) begin
      test_q <= test_nxt;
      corr_q <= corr_nxt;
      cyc_q  <= cyc_nxt;
      wdog_q <= wdog_nxt;
      exit_q <= exit_nxt;
      idx_q  <= idx_nxt;
      if (done_hit)                     state_q <= ST_DONE;
      else if (wdog_nxt == TimeoutCyc)  state_q <= ST_TIMEOUT;
    end
  end

`ifdef MLP_RUN_MONITOR_LAT_EN
  logic [NumCh*32-1:0] lat_cnt_q, lat_min_q, lat_max_q, lat_meas;

  // The measured gap includes the cycle of the RESULT write itself.
  always_comb begin
    lat_meas = '0;
    for (int c = 0; c < NumCh; c++) begin
      lat_meas[c*32 +: 32] = (&lat_cnt_q[c*32 +: 32]) ? 32'hFFFF_FFFF
                                                      : lat_cnt_q[c*32 +: 32] + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lat_cnt_q <= '0;
      lat_min_q <= '1;
      lat_max_q <= '0;
    end else if (start_i) begin
      lat_cnt_q <= '0;
      lat_min_q <= '1;
      lat_max_q <= '0;
    end else if (state_q == ST_RUN) begin
      for (int c = 0; c < NumCh; c++) begin
        if (hit_res[c]) begin
          lat_cnt_q[c*32 +: 32] <= '0;
          if (lat_meas[c*32 +: 32] < lat_min_q[c*32 +: 32])
            lat_min_q[c*32 +: 32] <= lat_meas[c*32 +: 32];
          if (lat_meas[c*32 +: 32] > lat_max_q[c*32 +: 32])
            lat_max_q[c*32 +: 32] <= lat_meas[c*32 +: 32];
        end else begin
          lat_cnt_q[c*32 +: 32] <= lat_meas[c*32 +: 32];
        end
      end
    end
  end

  assign lat_min_o = lat_min_q;
  assign lat_max_o = lat_max_q;
`endif

  assign busy_o        = (state_q == ST_RUN);
  assign done_o        = (state_q == ST_DONE);
  assign timeout_o     = (state_q == ST_TIMEOUT);
  assign test_cnt_o    = test_q;
  assign correct_cnt_o = corr_q;
  assign cycle_cnt_o   = cyc_q;
  assign ch_exit_o     = exit_q;
  assign last_idx_o    = idx_q;

endmodule
